// File: rtl/cnn_pkg.sv
// Shared types and constants for the pooling read path.
// Latency: none (types and constants only).
// Backpressure: none; the reader keeps no downstream handshake.
package cnn_pkg;

  // Each 2x2 pooling window is read as four pixels.
  localparam int POOL_WIN = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SLOT,
    WAIT,
    FLUSH
  } pool_rd_state_t;

  // A token that travels alongside the RAM read latency.
  typedef struct packed {
    logic run;
    logic clr;
  } pool_tok_t;

endpackage

// File: rtl/pool_window_reader_if.sv
// Bundles the reader's control, buffer-RAM and pooler-facing signals.
// Latency: none (wiring only).
// Backpressure: none; the RAM and the pooler accept one item every cycle.
interface pool_window_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  run_out;
  logic                  clear_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;

  // The reader drives this side.
  modport master (
    input  start, mem_data,
    output mem_rd_en, mem_addr, run_out, clear_out, data_out, busy, done
  );

  // The RAM, pooler and controller drive this side.
  modport slave (
    output start, mem_data,
    input  mem_rd_en, mem_addr, run_out, clear_out, data_out, busy, done
  );
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that delays tokens to line up with RAM read data.
// Latency: DEPTH cycles from i_dat to o_dat.
// Backpressure: none; it shifts every cycle. o_busy is high while any stage holds a set bit.
module valid_delay_line #(
  parameter type T     = logic,
  parameter int  DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  T     i_dat,
  output T     o_dat,
  output logic o_busy
);

  T r_stage [DEPTH];

  // Shift tokens one stage per cycle. Reset empties every stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dat = r_stage[DEPTH-1];

  // The line counts as occupied while any stage holds a token.
  always_comb begin
    o_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) o_busy = o_busy | (|r_stage[i]);
  end

endmodule

// File: rtl/pool_window_reader.sv
// Walks the feature map one 2x2 window at a time and feeds pixels and window-close strobes to the pooler.
// Latency: first read one cycle after start; run_out MEM_LATENCY cycles after each read.
// Backpressure: none. POOL_READ_OVERLAP_EN defined lets the next window issue right after the close slot.
module pool_window_reader
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int MEM_LATENCY = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  pool_window_reader_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] C_ROW     = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] C_WC_LAST = ADDR_WIDTH'(IMG_W/2 - 1);
  localparam logic [ADDR_WIDTH-1:0] C_WR_LAST = ADDR_WIDTH'(IMG_H/2 - 1);
  // From the last window of a window-row to the first window of the next one: down two rows, back to column 0.
  localparam logic [ADDR_WIDTH-1:0] C_ROW_JUMP = ADDR_WIDTH'(IMG_W + 2);

  pool_rd_state_t        r_state, w_state_nxt;
  logic [1:0]            r_rd_cnt, w_rd_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_wc, w_wc_nxt;
  logic [ADDR_WIDTH-1:0] r_wr, w_wr_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [2:0]            r_wait_cnt, w_wait_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  w_last_win;
  logic                  w_pipe_busy;
  logic                  w_done;
  pool_tok_t             w_tok_in, w_tok_out;

  assign w_last_win = (r_wc == C_WC_LAST) && (r_wr == C_WR_LAST);

  // Next state and next window position. r_base holds the top-left address of the window, so no multiply is needed.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    w_wc_nxt     = r_wc;
    w_wr_nxt     = r_wr;
    w_base_nxt   = r_base;
    w_wait_nxt   = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt  = ISSUE;
          w_rd_cnt_nxt = 2'd0;
          w_wc_nxt     = '0;
          w_wr_nxt     = '0;
          w_base_nxt   = '0;
        end
      end
      ISSUE: begin
        if (r_rd_cnt == 2'(POOL_WIN - 1)) w_state_nxt = SLOT;
        else                              w_rd_cnt_nxt = r_rd_cnt + 2'd1;
      end
      SLOT: begin
        if (w_last_win) begin
          w_state_nxt = FLUSH;
        end else begin
          w_rd_cnt_nxt = 2'd0;
          if (r_wc == C_WC_LAST) begin
            w_wc_nxt   = '0;
            w_wr_nxt   = r_wr + 1'b1;
            w_base_nxt = r_base + C_ROW_JUMP;
          end else begin
            w_wc_nxt   = r_wc + 1'b1;
            w_base_nxt = r_base + ADDR_WIDTH'(2);
          end
`ifdef POOL_READ_OVERLAP_EN
          w_state_nxt = ISSUE;
`else
          w_state_nxt = WAIT;
          w_wait_nxt  = 3'(MEM_LATENCY - 1);
`endif
        end
      end
      WAIT: begin
        if (r_wait_cnt == 3'd0) w_state_nxt = ISSUE;
        else                    w_wait_nxt  = r_wait_cnt - 3'd1;
      end
      FLUSH: begin
        if (!w_pipe_busy) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Read order inside a window: (r,c), (r,c+1), (r+1,c), (r+1,c+1).
    w_addr_nxt = w_base_nxt + (w_rd_cnt_nxt[1] ? C_ROW : '0) + ADDR_WIDTH'(w_rd_cnt_nxt[0]);
  end

  // State, counters and the registered read strobe and address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rd_cnt    <= 2'd0;
      r_wc        <= '0;
      r_wr        <= '0;
      r_base      <= '0;
      r_wait_cnt  <= 3'd0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_wc        <= w_wc_nxt;
      r_wr        <= w_wr_nxt;
      r_base      <= w_base_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_mem_rd_en <= (w_state_nxt == ISSUE);
      if (w_state_nxt == ISSUE) r_mem_addr <= w_addr_nxt;
    end
  end

  // A read launches a run token. The close slot launches a clear token on the same timing.
  always_comb begin
    w_tok_in     = '0;
    w_tok_in.run = r_mem_rd_en;
    w_tok_in.clr = (r_state == SLOT);
  end

  valid_delay_line #(
    .T     (pool_tok_t),
    .DEPTH (MEM_LATENCY)
  ) u_valid_delay_line (
    .clk     (clk),
    .reset_n (reset_n),
    .i_dat   (w_tok_in),
    .o_dat   (w_tok_out),
    .o_busy  (w_pipe_busy)
  );

  assign w_done        = (r_state == FLUSH) && !w_pipe_busy;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.run_out   = w_tok_out.run;
  assign bus.clear_out = w_tok_out.clr;
  // data_out is zeroed outside run cycles, so stale RAM data never reaches the pooler.
  assign bus.data_out  = w_tok_out.run ? bus.mem_data : {DATA_WIDTH{1'b0}};
  assign bus.done      = w_done;
  assign bus.busy      = (r_state != IDLE) && !w_done;

endmodule

// File: tb/tb_pool_window_reader.sv
// Directed bench for pool_window_reader on a 4x4 map: DUT A with MEM_LATENCY=1, DUT B with MEM_LATENCY=3.
// Latency: expected cycle numbers count from the cycle in which start is driven (cycle 0).
// Backpressure: none; the RAM models answer every read.
module tb_pool_window_reader;

`ifdef POOL_READ_OVERLAP_EN
  localparam int EXP_A_LAST_CLR = 21;
  localparam int EXP_A_DONE     = 22;
  localparam int EXP_B_GAP      = 5;
  localparam int EXP_B_DONE     = 24;
`else
  localparam int EXP_A_LAST_CLR = 24;
  localparam int EXP_A_DONE     = 25;
  localparam int EXP_B_GAP      = 8;
  localparam int EXP_B_DONE     = 33;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int exp_addr [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int exp_pool [4]  = '{0, 0, 5, 7};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pool_window_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) ia ();
  pool_window_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) ib ();

  pool_window_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .IMG_W(4), .IMG_H(4), .MEM_LATENCY(1))
    u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  pool_window_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .IMG_W(4), .IMG_H(4), .MEM_LATENCY(3))
    u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

  // RAM models with RAM[a] = a - 8; the valid flags mark cycles that carry returned data.
  logic signed [15:0] a_pd = '0;
  logic               a_pv = 1'b0;
  logic signed [15:0] b_pd [3] = '{default: '0};
  logic               b_pv [3] = '{default: 1'b0};

  always @(posedge clk) begin
    a_pd <= ia.mem_rd_en ? 16'(int'(ia.mem_addr) - 8) : 16'sd0;
    a_pv <= ia.mem_rd_en;
    b_pd[0] <= ib.mem_rd_en ? 16'(int'(ib.mem_addr) - 8) : 16'sd0;
    b_pv[0] <= ib.mem_rd_en;
    b_pd[1] <= b_pd[0];  b_pv[1] <= b_pv[0];
    b_pd[2] <= b_pd[1];  b_pv[2] <= b_pv[1];
  end
  assign ia.mem_data = a_pd;
  assign ib.mem_data = b_pd[2];

  // Event logs and a MaxPool2x2 + ReLU pooler model, one set per DUT.
  int qa_addr[$], qa_rdcyc[$], qa_pool[$], qa_clr[$], qa_done[$];
  int qb_addr[$], qb_pool[$], qb_clr[$], qb_done[$];
  int a_acc, b_acc, a_ovl = 0, b_ovl = 0, a_vmis = 0, b_vmis = 0, va, vb;
  bit a_have = 0, b_have = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      a_have = 0;
    end else begin
      if (ia.mem_rd_en) begin qa_addr.push_back(int'(ia.mem_addr)); qa_rdcyc.push_back(cyc); end
      if (ia.run_out && ia.clear_out) a_ovl++;
      if (ia.run_out != a_pv) a_vmis++;
      if (ia.run_out) begin
        va = int'($signed(ia.data_out));
        if (!a_have || va > a_acc) a_acc = va;
        a_have = 1;
      end
      if (ia.clear_out) begin
        qa_pool.push_back((a_have && a_acc > 0) ? a_acc : 0);
        qa_clr.push_back(cyc);
        a_have = 0;
      end
      if (ia.done) qa_done.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      b_have = 0;
    end else begin
      if (ib.mem_rd_en) qb_addr.push_back(int'(ib.mem_addr));
      if (ib.run_out && ib.clear_out) b_ovl++;
      if (ib.run_out != b_pv[2]) b_vmis++;
      if (ib.run_out) begin
        vb = int'($signed(ib.data_out));
        if (!b_have || vb > b_acc) b_acc = vb;
        b_have = 1;
      end
      if (ib.clear_out) begin
        qb_pool.push_back((b_have && b_acc > 0) ? b_acc : 0);
        qb_clr.push_back(cyc);
        b_have = 0;
      end
      if (ib.done) qb_done.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_a();
    outs_a = {1'b0, ia.mem_rd_en, ia.run_out, ia.clear_out, ia.busy, ia.done, ia.mem_addr, ia.data_out};
  endfunction

  function automatic logic [31:0] outs_b();
    outs_b = {1'b0, ib.mem_rd_en, ib.run_out, ib.clear_out, ib.busy, ib.done, ib.mem_addr, ib.data_out};
  endfunction

  task automatic pulse_start(input bit which, output int t0);
    @(posedge clk); #1;
    if (which) ib.start = 1'b1;
    else       ia.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    ia.start = 1'b0;
    ib.start = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int max_cyc, output bit got);
    got = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (which ? ib.done : ia.done) got = 1;
    end
  endtask

  task automatic chk_addrs(input string tag, input bit which, input int n0);
    int act;
    for (int i = 0; i < 16; i++) begin
      if (which) act = (n0 + i < qb_addr.size()) ? qb_addr[n0 + i] : -1;
      else       act = (n0 + i < qa_addr.size()) ? qa_addr[n0 + i] : -1;
      chk(tag, act, exp_addr[i]);
    end
  endtask

  task automatic chk_pool(input string tag, input bit which, input int p0);
    int act;
    for (int i = 0; i < 4; i++) begin
      if (which) act = (p0 + i < qb_pool.size()) ? qb_pool[p0 + i] : -1;
      else       act = (p0 + i < qa_pool.size()) ? qa_pool[p0 + i] : -1;
      chk(tag, act, exp_pool[i]);
    end
  endtask

  initial begin
    int t0, t1, n0, p0, c0, d0;
    bit got;
    reset_n  = 1'b0;
    ia.start = 1'b0;
    ib.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs_a", outs_a(), 0);
    chk("rst_outs_b", outs_b(), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1/T2/T3: one full pass on DUT A
    n0 = qa_addr.size(); p0 = qa_pool.size(); c0 = qa_clr.size(); d0 = qa_done.size();
    pulse_start(0, t0);
    @(negedge clk);
    chk("busy_cycle1", int'(ia.busy), 1);
    chk("rd_en_cycle1", int'(ia.mem_rd_en), 1);
    wait_done(0, 200, got);
    chk("t1_done_seen", int'(got), 1);
    chk("busy_at_done", int'(ia.busy), 0);
    ia.start = 1'b1;                    // start in the done cycle must be ignored
    @(posedge clk); #1;
    ia.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_cycle_start_ignored", int'(ia.busy), 0);
    chk("t1_reads", qa_addr.size() - n0, 16);
    chk_addrs("t1_addr", 0, n0);
    chk("t3_first_rd", (qa_rdcyc.size() > n0) ? qa_rdcyc[n0] - t0 : -1, 1);
    chk("t1_clears", qa_clr.size() - c0, 4);
    chk("t3_last_clr", (qa_clr.size() > c0) ? qa_clr[$] - t0 : -1, EXP_A_LAST_CLR);
    chk("t3_done_cyc", (qa_done.size() > d0) ? qa_done[$] - t0 : -1, EXP_A_DONE);
    chk("t2_done_count", qa_done.size() - d0, 1);
    chk_pool("t2_pool", 0, p0);

    // T4: a second start mid-pass has no effect
    n0 = qa_addr.size(); d0 = qa_done.size();
    pulse_start(0, t0);
    repeat (5) @(posedge clk);
    pulse_start(0, t1);
    wait_done(0, 200, got);
    chk("t4_done_seen", int'(got), 1);
    @(negedge clk);
    chk("t4_reads", qa_addr.size() - n0, 16);
    chk_addrs("t4_addr", 0, n0);
    chk("t4_done_cyc", (qa_done.size() > d0) ? qa_done[$] - t0 : -1, EXP_A_DONE);
    chk("t4_done_count", qa_done.size() - d0, 1);

    // T5: reset during window 2, then a fresh pass
    d0 = qa_done.size();
    pulse_start(0, t0);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_outs_in_reset", outs_a(), 0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_no_done", qa_done.size() - d0, 0);
    chk("t5_idle_outs", outs_a(), 0);
    n0 = qa_addr.size(); p0 = qa_pool.size();
    pulse_start(0, t0);
    wait_done(0, 200, got);
    chk("t5_done_seen", int'(got), 1);
    @(negedge clk);
    chk("t5_reads", qa_addr.size() - n0, 16);
    chk_addrs("t5_addr", 0, n0);
    chk_pool("t5_pool", 0, p0);

    // T6: DUT B with MEM_LATENCY=3
    n0 = qb_addr.size(); p0 = qb_pool.size(); c0 = qb_clr.size(); d0 = qb_done.size();
    pulse_start(1, t0);
    wait_done(1, 300, got);
    chk("t6_done_seen", int'(got), 1);
    @(negedge clk);
    chk("t6_reads", qb_addr.size() - n0, 16);
    chk_addrs("t6_addr", 1, n0);
    chk("t6_clears", qb_clr.size() - c0, 4);
    for (int i = 1; i < 4; i++)
      chk("t6_clear_gap", (qb_clr.size() > c0 + i) ? qb_clr[c0 + i] - qb_clr[c0 + i - 1] : -1, EXP_B_GAP);
    chk("t6_done_cyc", (qb_done.size() > d0) ? qb_done[$] - t0 : -1, EXP_B_DONE);
    chk_pool("t6_pool", 1, p0);

    chk("a_run_clear_overlap", a_ovl, 0);
    chk("a_run_vs_data_valid", a_vmis, 0);
    chk("b_run_clear_overlap", b_ovl, 0);
    chk("b_run_vs_data_valid", b_vmis, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
